bsg_wormhole_router_test_responder: RTL and testbench

BSG_WORMHOLE_ROUTER_TEST_RESPONDER -- requirements
Module: bsg_wormhole_router_test_responder

---
 rtl/bsg_wormhole_router_test_responder.sv | 238 +++++++++++++++++++++++
 tb/tb_bsg_wormhole_router_test_responder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/bsg_wormhole_router_test_responder.sv
// ---------------------------------------------------------------------------
// bsg_wormhole_router_test_responder
//
// Purpose:
//   Wormhole-router test endpoint. It accepts one request packet, which is a
//   header flit followed by `len` body flits. It then answers with one
//   response packet: a header addressed back to the requester, followed by the
//   same body flits in their original order. The block is half-duplex. It
//   never accepts input while it is sending.
//
//   Header flit layout (LSB first):
//     [cord_width_p-1:0]                 dest cord
//     next len_width_p bits              len (number of body flits)
//     next cord_width_p bits             src cord
//     remaining upper bits               zero
//   The response header is {zeros, my_cord_i, len, src}.
//
//   A packet with len > max_len_p cannot be buffered. Its body is discarded,
//   the sticky error flag is raised, and no response is sent.
//
// Optional feature:
//   BSG_WORMHOLE_ROUTER_TEST_RESPONDER_CORD_CHECK_EN -- when this macro is
//   defined, a header whose dest cord differs from my_cord_i is treated as
//   misrouted. Its body is discarded and error_o is raised. When the macro is
//   undefined, the dest cord is ignored.
//
// Ports:
//   clk_i         rising-edge clock
//   reset_i       asynchronous active-high reset
//   my_cord_i     this node's coordinate (quasi-static)
//   v_i/data_i/ready_and_o    inbound request flit link
//   v_o/data_o/ready_and_i    outbound response flit link
//   error_o       sticky protocol error flag
//   resp_count_o  count of completed responses (wraps at 16 bits)
// ---------------------------------------------------------------------------
module bsg_wormhole_router_test_responder #(
    parameter int flit_width_p = 16,
    parameter int cord_width_p = 5,
    parameter int len_width_p  = 3,
    parameter int max_len_p    = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [cord_width_p-1:0] my_cord_i,

    input  logic                    v_i,
    input  logic [flit_width_p-1:0] data_i,
    output logic                    ready_and_o,

    output logic                    v_o,
    output logic [flit_width_p-1:0] data_o,
    input  logic                    ready_and_i,

    output logic                    error_o,
    output logic [15:0]             resp_count_o
);

    // The buffer is addressed by the low bits of the flit counter. That is
    // enough because a stored packet never holds more than max_len_p flits.
    localparam int addr_w = (max_len_p > 1) ? $clog2(max_len_p) : 1;
    localparam int depth  = 2 ** addr_w;

    localparam logic [len_width_p-1:0] max_len_lp = len_width_p'(max_len_p);
    localparam logic [len_width_p-1:0] one_lp     = len_width_p'(1);

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        DRAIN,
        SEND_HDR,
        SEND_BODY
    } state_t;

    state_t                  state_reg, state_next;
    logic [len_width_p-1:0]  cnt_reg, cnt_next;
    logic [len_width_p-1:0]  len_reg, len_next;
    logic [cord_width_p-1:0] src_reg, src_next;
    logic                    error_reg, error_next;
    logic [15:0]             resp_count_reg, resp_count_next;
    // ready_and_o is held low until one clock edge after reset is released.
    logic                    ready_en_reg;

    logic [flit_width_p-1:0] mem [depth];
    logic                    mem_we;

    // Header fields of the incoming flit
    logic [cord_width_p-1:0] hdr_dest;
    logic [len_width_p-1:0]  hdr_len;
    logic [cord_width_p-1:0] hdr_src;
    logic                    hdr_misrouted;

    assign hdr_dest = data_i[cord_width_p-1:0];
    assign hdr_len  = data_i[cord_width_p +: len_width_p];
    assign hdr_src  = data_i[cord_width_p+len_width_p +: cord_width_p];

`ifdef BSG_WORMHOLE_ROUTER_TEST_RESPONDER_CORD_CHECK_EN
    assign hdr_misrouted = (hdr_dest != my_cord_i);
`else
    assign hdr_misrouted = 1'b0;
`endif

    // This sink keeps the dest cord bits and the zero upper header bits
    // visible, so they are not reported as unused.
    logic unused_hdr_bits;
    assign unused_hdr_bits = ^{data_i, hdr_dest};

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            len_reg        <= '0;
            src_reg        <= '0;
            error_reg      <= 1'b0;
            resp_count_reg <= '0;
            ready_en_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            len_reg        <= len_next;
            src_reg        <= src_next;
            error_reg      <= error_next;
            resp_count_reg <= resp_count_next;
            ready_en_reg   <= 1'b1;
        end
    end

    // The body buffer has no reset. Stale contents are never read, because
    // every flit sent was first written by the current packet.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[cnt_reg[addr_w-1:0]] <= data_i;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        len_next        = len_reg;
        src_next        = src_reg;
        error_next      = error_reg;
        resp_count_next = resp_count_reg;
        mem_we          = 1'b0;
        ready_and_o     = 1'b0;
        v_o             = 1'b0;
        data_o          = '0;

        case (state_reg)
            IDLE: begin
                ready_and_o = ready_en_reg;
                if (v_i && ready_en_reg) begin
                    len_next = hdr_len;
                    src_next = hdr_src;
                    cnt_next = '0;
                    if (hdr_misrouted || (hdr_len > max_len_lp)) begin
                        error_next = 1'b1;
                        // A misrouted zero-length header has no body to
                        // discard, so the block stays in IDLE.
                        state_next = (hdr_len == '0) ? IDLE : DRAIN;
                    end else if (hdr_len == '0) begin
                        state_next = SEND_HDR;
                    end else begin
                        state_next = RECV;
                    end
                end
            end

            RECV: begin
                ready_and_o = 1'b1;
                if (v_i) begin
                    mem_we = 1'b1;
                    // len_reg <= max_len_p here, so cnt_reg + 1 cannot wrap
                    if ((cnt_reg + one_lp) == len_reg) begin
                        cnt_next   = '0;
                        state_next = SEND_HDR;
                    end else begin
                        cnt_next = cnt_reg + one_lp;
                    end
                end
            end

            DRAIN: begin
                ready_and_o = 1'b1;
                if (v_i) begin
                    if ((cnt_reg + one_lp) == len_reg) begin
                        cnt_next   = '0;
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt_reg + one_lp;
                    end
                end
            end

            SEND_HDR: begin
                v_o = 1'b1;
                data_o[cord_width_p-1:0]                         = src_reg;
                data_o[cord_width_p +: len_width_p]              = len_reg;
                data_o[cord_width_p+len_width_p +: cord_width_p] = my_cord_i;
                if (ready_and_i) begin
                    cnt_next = '0;
                    if (len_reg == '0) begin
                        resp_count_next = resp_count_reg + 16'd1;
                        state_next      = IDLE;
                    end else begin
                        state_next = SEND_BODY;
                    end
                end
            end

            SEND_BODY: begin
                v_o    = 1'b1;
                data_o = mem[cnt_reg[addr_w-1:0]];
                if (ready_and_i) begin
                    if ((cnt_reg + one_lp) == len_reg) begin
                        cnt_next        = '0;
                        resp_count_next = resp_count_reg + 16'd1;
                        state_next      = IDLE;
                    end else begin
                        cnt_next = cnt_reg + one_lp;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign error_o      = error_reg;
    assign resp_count_o = resp_count_reg;

endmodule

// File: tb/tb_bsg_wormhole_router_test_responder.sv
// ---------------------------------------------------------------------------
// Testbench for bsg_wormhole_router_test_responder
// (flit 16, cord 5, len 3, max_len 4, my_cord 3).
// A table of per-cycle vectors covers the normal, zero-length and over-length
// packets. Hand-written sequences cover backpressure, reset during a send,
// and the dest cord check. The expected cord-check results follow the macro
// BSG_WORMHOLE_ROUTER_TEST_RESPONDER_CORD_CHECK_EN.
// ---------------------------------------------------------------------------
module tb_bsg_wormhole_router_test_responder;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [4:0]  my_cord_i;
    logic        v_i;
    logic [15:0] data_i;
    logic        ready_and_o;
    logic        v_o;
    logic [15:0] data_o;
    logic        ready_and_i;
    logic        error_o;
    logic [15:0] resp_count_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bsg_wormhole_router_test_responder #(
        .flit_width_p(16),
        .cord_width_p(5),
        .len_width_p (3),
        .max_len_p   (4)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .my_cord_i   (my_cord_i),
        .v_i         (v_i),
        .data_i      (data_i),
        .ready_and_o (ready_and_o),
        .v_o         (v_o),
        .data_o      (data_o),
        .ready_and_i (ready_and_i),
        .error_o     (error_o),
        .resp_count_o(resp_count_o)
    );

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        r;
        logic        erdy;
        logic        ev;
        logic [15:0] ed;
        logic        eerr;
        logic [15:0] ecnt;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(logic v, logic [15:0] d, logic r, logic erdy,
                                logic ev, logic [15:0] ed, logic eerr,
                                logic [15:0] ecnt);
        vec_t x;
        x.v = v; x.d = d; x.r = r; x.erdy = erdy; x.ev = ev; x.ed = ed;
        x.eerr = eerr; x.ecnt = ecnt;
        return x;
    endfunction

    task automatic chk1(input string name, input logic [15:0] got,
                        input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, got, exp);
        end
    endtask

    // Check every output against its expected value.
    task automatic check_outs(input string name, input logic erdy,
                              input logic ev, input logic [15:0] ed,
                              input logic eerr, input logic [15:0] ecnt);
        chk1({name, " ready_and_o"}, 16'(ready_and_o), 16'(erdy));
        chk1({name, " v_o"}, 16'(v_o), 16'(ev));
        if (ev) chk1({name, " data_o"}, data_o, ed);
        chk1({name, " error_o"}, 16'(error_o), 16'(eerr));
        chk1({name, " resp_count_o"}, resp_count_o, ecnt);
    endtask

    // One cycle: drive the inputs at the falling edge, then check the outputs
    // that are valid before the next rising edge.
    task automatic cyc(input string name, input logic v, input logic [15:0] d,
                       input logic r, input logic erdy, input logic ev,
                       input logic [15:0] ed, input logic eerr,
                       input logic [15:0] ecnt);
        @(negedge clk);
        v_i = v; data_i = d; ready_and_i = r;
        #1;
        check_outs(name, erdy, ev, ed, eerr, ecnt);
        $display("cycle %-12s v_i=%0b data_i=%04h rdy_i=%0b | rdy_o=%0b v_o=%0b data_o=%04h err=%0b cnt=%0d",
                 name, v, d, r, ready_and_o, v_o, data_o, error_o, resp_count_o);
    endtask

    initial begin
        // Normal packet, then zero-length, over-length, and a follow-up packet
        tbl[0]  = mk(1, 16'h0A43, 1, 1, 0, 16'h0000, 0, 0);
        tbl[1]  = mk(1, 16'h1111, 1, 1, 0, 16'h0000, 0, 0);
        tbl[2]  = mk(1, 16'h2222, 1, 1, 0, 16'h0000, 0, 0);
        tbl[3]  = mk(1, 16'hFFFF, 1, 0, 1, 16'h034A, 0, 0); // input ignored
        tbl[4]  = mk(0, 16'h0000, 1, 0, 1, 16'h1111, 0, 0);
        tbl[5]  = mk(0, 16'h0000, 1, 0, 1, 16'h2222, 0, 0);
        tbl[6]  = mk(1, 16'h0A03, 1, 1, 0, 16'h0000, 0, 1);
        tbl[7]  = mk(0, 16'h0000, 1, 0, 1, 16'h030A, 0, 1);
        tbl[8]  = mk(1, 16'h0AA3, 1, 1, 0, 16'h0000, 0, 2);
        tbl[9]  = mk(1, 16'hAAAA, 1, 1, 0, 16'h0000, 1, 2);
        tbl[10] = mk(1, 16'hBBBB, 1, 1, 0, 16'h0000, 1, 2);
        tbl[11] = mk(1, 16'hCCCC, 1, 1, 0, 16'h0000, 1, 2);
        tbl[12] = mk(1, 16'hDDDD, 1, 1, 0, 16'h0000, 1, 2);
        tbl[13] = mk(1, 16'hEEEE, 1, 1, 0, 16'h0000, 1, 2);
        tbl[14] = mk(1, 16'h0A43, 1, 1, 0, 16'h0000, 1, 2);
        tbl[15] = mk(1, 16'h5555, 1, 1, 0, 16'h0000, 1, 2);
        tbl[16] = mk(1, 16'h6666, 1, 1, 0, 16'h0000, 1, 2);
        tbl[17] = mk(0, 16'h0000, 1, 0, 1, 16'h034A, 1, 2);
        tbl[18] = mk(0, 16'h0000, 1, 0, 1, 16'h5555, 1, 2);
        tbl[19] = mk(0, 16'h0000, 1, 0, 1, 16'h6666, 1, 2);
        tbl[20] = mk(0, 16'h0000, 1, 1, 0, 16'h0000, 1, 3);

        my_cord_i   = 5'd3;
        v_i         = 1'b0;
        data_i      = '0;
        ready_and_i = 1'b1;
        reset_i     = 1'b1;

        // Reset state
        @(negedge clk);
        #1;
        check_outs("reset", 0, 0, 16'h0, 0, 0);
        @(negedge clk);
        reset_i = 1'b0;
        #1;
        chk1("post-reset ready_and_o", 16'(ready_and_o), 16'h0);

        for (int i = 0; i < 21; i++) begin
            cyc($sformatf("tbl[%0d]", i), tbl[i].v, tbl[i].d, tbl[i].r,
                tbl[i].erdy, tbl[i].ev, tbl[i].ed, tbl[i].eerr, tbl[i].ecnt);
        end

        // Backpressure: the header is held for 3 cycles
        cyc("bp hdr",  1, 16'h0A43, 1, 1, 0, 16'h0, 1, 3);
        cyc("bp b0",   1, 16'h1234, 1, 1, 0, 16'h0, 1, 3);
        cyc("bp b1",   1, 16'h5678, 1, 1, 0, 16'h0, 1, 3);
        for (int i = 0; i < 3; i++)
            cyc($sformatf("bp hold%0d", i), 1, 16'hFFFF, 0, 0, 1, 16'h034A, 1, 3);
        cyc("bp out0", 0, 16'h0, 1, 0, 1, 16'h034A, 1, 3);
        cyc("bp out1", 0, 16'h0, 1, 0, 1, 16'h1234, 1, 3);
        cyc("bp out2", 0, 16'h0, 1, 0, 1, 16'h5678, 1, 3);
        cyc("bp idle", 0, 16'h0, 1, 1, 0, 16'h0, 1, 4);

        // Reset after the first response flit has been sent
        cyc("rs hdr",  1, 16'h0A43, 1, 1, 0, 16'h0, 1, 4);
        cyc("rs b0",   1, 16'h1357, 1, 1, 0, 16'h0, 1, 4);
        cyc("rs b1",   1, 16'h2468, 1, 1, 0, 16'h0, 1, 4);
        cyc("rs out0", 0, 16'h0, 1, 0, 1, 16'h034A, 1, 4);
        cyc("rs out1", 0, 16'h0, 0, 0, 1, 16'h1357, 1, 4);
        reset_i = 1'b1;
        #1;
        check_outs("rs async", 0, 0, 16'h0, 0, 0);
        @(negedge clk);
        reset_i     = 1'b0;
        ready_and_i = 1'b1;
        #1;
        chk1("rs release ready_and_o", 16'(ready_and_o), 16'h0);
        cyc("rs2 hdr",  1, 16'h0A43, 1, 1, 0, 16'h0, 0, 0);
        cyc("rs2 b0",   1, 16'h0BAD, 1, 1, 0, 16'h0, 0, 0);
        cyc("rs2 b1",   1, 16'hCAFE, 1, 1, 0, 16'h0, 0, 0);
        cyc("rs2 out0", 0, 16'h0, 1, 0, 1, 16'h034A, 0, 0);
        cyc("rs2 out1", 0, 16'h0, 1, 0, 1, 16'h0BAD, 0, 0);
        cyc("rs2 out2", 0, 16'h0, 1, 0, 1, 16'hCAFE, 0, 0);

        // Dest cord check: header for cord 4, len 1
        cyc("cc hdr",   1, 16'h0A24, 1, 1, 0, 16'h0, 0, 1);
`ifdef BSG_WORMHOLE_ROUTER_TEST_RESPONDER_CORD_CHECK_EN
        cyc("cc body",  1, 16'h7777, 1, 1, 0, 16'h0, 1, 1);
        cyc("cc quiet0", 0, 16'h0, 1, 1, 0, 16'h0, 1, 1);
        cyc("cc quiet1", 0, 16'h0, 1, 1, 0, 16'h0, 1, 1);
`else
        cyc("cc body",  1, 16'h7777, 1, 1, 0, 16'h0, 0, 1);
        cyc("cc out0",  0, 16'h0, 1, 0, 1, 16'h032A, 0, 1);
        cyc("cc out1",  0, 16'h0, 1, 0, 1, 16'h7777, 0, 1);
        cyc("cc idle",  0, 16'h0, 1, 1, 0, 16'h0, 0, 2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
